// File: rtl/sd_photo_pkg.sv
// Shared types and widths for the SD-card slideshow scheduler.
package sd_photo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_H,
    WAIT_L,
    HOLD
  } state_e;

  localparam int SEC_CNT_W = 11;
  localparam int HOLD_W    = 28;
  localparam int TO_W      = 10;
  localparam int LD_W      = 8;

  function automatic logic [31:0] sec_addr(
    input logic [31:0]          base,
    input logic [SEC_CNT_W-1:0] cnt
  );
    return base + {{(32-SEC_CNT_W){1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/sd_photo_addr_gen.sv
// Photo index, photo base sector and in-photo sector counter.
import sd_photo_pkg::*;

module sd_photo_addr_gen #(
  parameter int          PHOTO_NUM     = 2,
  parameter int          SEC_PER_PHOTO = 1500,
  parameter logic [31:0] SEC_ADDR0     = 32'd16640,
  parameter logic [31:0] SEC_STRIDE    = 32'd2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_sec,
  input  logic                 step_sec,
  input  logic                 advance,
  output logic [7:0]           photo_idx,
  output logic [31:0]          base,
  output logic [SEC_CNT_W-1:0] sec_cnt,
  output logic                 sec_last
);

  localparam logic [7:0] IDX_LAST = 8'(PHOTO_NUM - 1);
  localparam logic [SEC_CNT_W-1:0] SEC_LAST =
    SEC_CNT_W'(SEC_PER_PHOTO - 1);

  logic wrap;

  assign sec_last = (sec_cnt == SEC_LAST);
  assign wrap     = (photo_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= '0;
    end else if (clr_sec) begin
      sec_cnt <= '0;
    end else if (step_sec) begin
      sec_cnt <= sec_last ? '0 : sec_cnt + 1'b1;
    end
  end

  // Base tracks the index incrementally so no multiplier is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      photo_idx <= '0;
      base      <= SEC_ADDR0;
    end else if (advance) begin
      photo_idx <= wrap ? 8'd0 : photo_idx + 8'd1;
      base      <= wrap ? SEC_ADDR0 : base + SEC_STRIDE;
    end
  end

endmodule

// File: rtl/sd_photo_sched.sv
// Slideshow scheduler: reload frame buffer, read one photo sector by
// sector, hold it on screen, then advance to the next photo.
import sd_photo_pkg::*;

module sd_photo_sched #(
  parameter int          PHOTO_NUM     = 2,
  parameter int          SEC_PER_PHOTO = 1500,
  parameter logic [31:0] SEC_ADDR0     = 32'd16640,
  parameter logic [31:0] SEC_STRIDE    = 32'd2048,
  parameter int          HOLD_CYCLES   = 150_000_000,
  parameter int          LOAD_CYCLES   = 4,
  parameter int          BUSY_TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        next,
  input  logic        rd_busy,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        wr_load,
  output logic [7:0]  photo_idx,
  output logic        photo_done
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [LD_W-1:0]   LD_LAST   = LD_W'(LOAD_CYCLES - 1);

  state_e               state;
  logic [TO_W-1:0]      to_cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [LD_W-1:0]      ld_cnt;
  logic [31:0]          base;
  logic [SEC_CNT_W-1:0] sec_cnt;
  logic                 sec_last;
  logic                 advance;
  logic                 go_load;
  logic                 step_sec;

  assign advance  = (state == HOLD) && start &&
                    (next || (hold_cnt == HOLD_LAST));
  assign go_load  = ((state == IDLE) && start) || advance;
  assign step_sec = (state == WAIT_L) && !rd_busy;

  sd_photo_addr_gen #(
    .PHOTO_NUM     (PHOTO_NUM),
    .SEC_PER_PHOTO (SEC_PER_PHOTO),
    .SEC_ADDR0     (SEC_ADDR0),
    .SEC_STRIDE    (SEC_STRIDE)
  ) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_sec   (go_load),
    .step_sec  (step_sec),
    .advance   (advance),
    .photo_idx (photo_idx),
    .base      (base),
    .sec_cnt   (sec_cnt),
    .sec_last  (sec_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_load     <= 1'b0;
      rd_start_en <= 1'b0;
      rd_sec_addr <= '0;
      photo_done  <= 1'b0;
      to_cnt      <= '0;
      hold_cnt    <= '0;
      ld_cnt      <= '0;
    end else begin
      rd_start_en <= 1'b0;
      photo_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            wr_load <= 1'b1;
            ld_cnt  <= '0;
          end
        end
        LOAD: begin
          if (!start) begin
            state   <= IDLE;
            wr_load <= 1'b0;
          end else if (ld_cnt == LD_LAST) begin
            state   <= ISSUE;
            wr_load <= 1'b0;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        ISSUE: begin
          rd_start_en <= 1'b1;
          rd_sec_addr <= sec_addr(base, sec_cnt);
          to_cnt      <= '0;
          state       <= WAIT_H;
        end
        // Timeout replays ISSUE; sec_cnt is untouched so address repeats.
        WAIT_H: begin
          if (rd_busy) begin
            state <= WAIT_L;
          end else if (to_cnt == TO_LAST) begin
            state <= ISSUE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_L: begin
          if (!rd_busy) begin
            photo_done <= sec_last;
            hold_cnt   <= '0;
            if (!start) begin
              state <= IDLE;
            end else if (sec_last) begin
              state <= HOLD;
            end else begin
              state <= ISSUE;
            end
          end
        end
        HOLD: begin
          if (!start) begin
            state <= IDLE;
          end else if (advance) begin
            state   <= LOAD;
            wr_load <= 1'b1;
            ld_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
